// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: vehicle phase lengths, pedestrian phase
// defaults and the pedestrian controller state encoding.
package traffic_pkg;

  localparam int unsigned GREEN_CYCLES  = 5;
  localparam int unsigned YELLOW_CYCLES = 2;
  localparam int unsigned RED_CYCLES    = 7;

  localparam int unsigned PED_CLEAR_CYCLES = 1;
  localparam int unsigned PED_WALK_CYCLES  = 3;
  localparam int unsigned PED_FLASH_CYCLES = 2;

  typedef enum logic [2:0] {
    PED_IDLE  = 3'd0,
    PED_CLEAR = 3'd1,
    PED_WALK  = 3'd2,
    PED_FLASH = 3'd3,
    PED_DONE  = 3'd4
  } ped_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_phase_timer.sv
// Loadable down-counter for pedestrian phase timing; saturates at zero.
module phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal controller: latches button requests and grants one
// clear/walk/flash sequence at each start of vehicle red.
module ped_crossing_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = PED_CLEAR_CYCLES,
  parameter int unsigned WALK_CYCLES  = PED_WALK_CYCLES,
  parameter int unsigned FLASH_CYCLES = PED_FLASH_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pass,
  input  logic button,
  output logic walk,
  output logic dont_walk,
  output logic req_pending
);

  localparam int unsigned CW = $clog2(max3(CLEAR_CYCLES, WALK_CYCLES, FLASH_CYCLES)) + 1;
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] WALK_LD  = CW'(WALK_CYCLES - 1);
  localparam logic [CW-1:0] FLASH_LD = CW'(FLASH_CYCLES - 1);

  ped_state_t    state_q, state_d;
  logic          req_q, req_d;
  logic          flash_q, flash_d;
  logic          pass_q;
  logic          red_start;
  logic          t_load, t_en, t_zero;
  logic [CW-1:0] t_val;

  phase_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .value  (t_val),
    .enable (t_en),
    .zero   (t_zero)
  );

  // pass_q resets low so a red already present at reset exit is not a red start
  assign red_start = pass_q & ~pass;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PED_IDLE;
      req_q   <= 1'b0;
      flash_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      flash_q <= flash_d;
      pass_q  <= pass;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    flash_d = flash_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;

    if (button && (state_q == PED_IDLE || state_q == PED_CLEAR || state_q == PED_DONE))
      req_d = 1'b1;

    case (state_q)
      PED_IDLE: begin
        if (red_start && (req_q || button)) begin
          state_d = PED_CLEAR;
          t_load  = 1'b1;
          t_val   = CLEAR_LD;
        end
      end
      PED_CLEAR: begin
        if (pass) begin
          state_d = PED_IDLE;
        end else if (t_zero) begin
          // request is consumed here; this clear overrides a same-cycle press
          state_d = PED_WALK;
          req_d   = 1'b0;
          t_load  = 1'b1;
          t_val   = WALK_LD;
        end else begin
          t_en = 1'b1;
        end
      end
      PED_WALK: begin
        if (pass) begin
          state_d = PED_IDLE;
        end else if (t_zero) begin
          state_d = PED_FLASH;
          flash_d = 1'b1;
          t_load  = 1'b1;
          t_val   = FLASH_LD;
        end else begin
          t_en = 1'b1;
        end
      end
      PED_FLASH: begin
        flash_d = ~flash_q;
        if (pass) begin
          state_d = PED_IDLE;
        end else if (t_zero) begin
          state_d = PED_DONE;
        end else begin
          t_en = 1'b1;
        end
      end
      PED_DONE: begin
        if (pass) state_d = PED_IDLE;
      end
      default: state_d = PED_IDLE;
    endcase
  end

  always_comb begin
    walk        = (state_q == PED_WALK);
    dont_walk   = 1'b1;
    req_pending = req_q;
    case (state_q)
      PED_WALK:  dont_walk = 1'b0;
      PED_FLASH: dont_walk = flash_q;
      default:   dont_walk = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: a vector table of per-cycle inputs and
// expected {walk, dont_walk, req_pending}, plus abort and mid-flash reset runs.
module tb_ped_crossing_ctrl;

  logic clk = 1'b0;
  logic rst, pass, button;
  logic walk, dont_walk, req_pending;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic       pass;
    logic       button;
    logic [2:0] exp;   // {walk, dont_walk, req_pending}
  } vec_t;

  vec_t vecs[$];

  ped_crossing_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pass        (pass),
    .button      (button),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  task automatic add_run(input int n, input logic r, input logic p, input logic b,
                         input logic [2:0] e);
    vec_t v;
    v.rst = r; v.pass = p; v.button = b; v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step(input string name, input logic r, input logic p, input logic b,
                      input logic [2:0] e);
    logic [2:0] act;
    @(negedge clk);
    rst = r; pass = p; button = b;
    @(posedge clk);
    #1;
    act = {walk, dont_walk, req_pending};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: {walk,dont_walk,req_pending} got %b expected %b",
               name, $time, act, e);
    end
    if (walk && dont_walk) begin
      n_fail++;
      $display("FAIL %s_exclusive @%0t: walk=%b dont_walk=%b expected not both 1",
               name, $time, walk, dont_walk);
    end
  endtask

  initial begin
    rst = 1'b0; pass = 1'b1; button = 1'b0;

    // reset
    add_run(2, 0, 1, 0, 3'b010);
    // button pulse in green, then serviced red
    add_run(1, 1, 1, 1, 3'b011);
    add_run(2, 1, 1, 0, 3'b011);
    add_run(1, 1, 0, 0, 3'b011);  // CLEAR
    add_run(3, 1, 0, 0, 3'b100);  // WALK
    add_run(1, 1, 0, 0, 3'b010);  // FLASH on
    add_run(1, 1, 0, 0, 3'b000);  // FLASH off
    add_run(1, 1, 0, 0, 3'b010);  // DONE
    // full light cycle without request
    add_run(7, 1, 1, 0, 3'b010);
    add_run(7, 1, 0, 0, 3'b010);
    // new request, then button during the last WALK cycle is ignored
    add_run(2, 1, 1, 1, 3'b011);
    add_run(1, 1, 0, 0, 3'b011);
    add_run(3, 1, 0, 0, 3'b100);
    add_run(1, 1, 0, 1, 3'b010);
    add_run(1, 1, 0, 0, 3'b000);
    add_run(1, 1, 0, 0, 3'b010);
    add_run(7, 1, 1, 0, 3'b010);
    add_run(7, 1, 0, 0, 3'b010);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].pass, vecs[i].button, vecs[i].exp);

    // abort: vehicles go again during the second WALK cycle
    step("abort_req",   1, 1, 1, 3'b011);
    step("abort_green", 1, 1, 0, 3'b011);
    step("abort_clear", 1, 0, 0, 3'b011);
    step("abort_walk1", 1, 0, 0, 3'b100);
    step("abort_walk2", 1, 0, 0, 3'b100);
    step("abort_hit",   1, 1, 0, 3'b010);
    for (int i = 0; i < 3; i++) step("abort_green2", 1, 1, 0, 3'b010);
    for (int i = 0; i < 7; i++) step("abort_red2",   1, 0, 0, 3'b010);

    // reset during flashing, button held across reset
    step("rf_req",   1, 1, 1, 3'b011);
    step("rf_clear", 1, 0, 0, 3'b011);
    for (int i = 0; i < 3; i++) step("rf_walk", 1, 0, 0, 3'b100);
    step("rf_flash1", 1, 0, 0, 3'b010);
    step("rf_flash0", 1, 0, 0, 3'b000);
    step("rf_reset",  0, 0, 1, 3'b010);
    for (int i = 0; i < 3; i++) step("rf_red_held", 1, 0, 0, 3'b010);
    step("rf_late_btn", 1, 0, 1, 3'b011);
    for (int i = 0; i < 3; i++) step("rf_wait", 1, 0, 0, 3'b011);
    step("rf_green",   1, 1, 0, 3'b011);
    step("rf_clear2",  1, 0, 0, 3'b011);
    step("rf_walk2",   1, 0, 0, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
